// File: rtl/mdu_pkg.sv
// Shared encodings and width for the iterative multiply/divide unit.
// Combinational definitions only; no state, no handshake.
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_e;

   // Bit 0 of the op selects signed, bit 1 selects divide.
   function automatic logic op_is_signed(input op_e op);
      return op[0];
   endfunction

   function automatic logic op_is_div(input op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/Busy/Done request bundle between control unit (master) and MDU (slave).
// No buffering; Start is only sampled by the slave while Busy is low.
interface mult_div_unit_if #(parameter int WIDTH = mdu_pkg::MDU_WIDTH);

   logic             i_start;
   mdu_pkg::op_e     i_op;
   logic [WIDTH-1:0] i_opa;
   logic [WIDTH-1:0] i_opb;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_hi;
   logic [WIDTH-1:0] o_lo;
   logic             o_div_zero;

   modport master (
      output i_start, i_op, i_opa, i_opb,
      input  o_busy, o_done, o_hi, o_lo, o_div_zero
   );

   modport slave (
      input  i_start, i_op, i_opa, i_opb,
      output o_busy, o_done, o_hi, o_lo, o_div_zero
   );

endinterface

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement negate; purely combinational, no handshake.
module mdu_cond_neg #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_dat,
   input  logic         i_neg,
   output logic [W-1:0] o_dat
);

   assign o_dat = i_neg ? (~i_dat + W'(1)) : i_dat;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU: WIDTH+2 cycles Start-to-Done, 2 for divide-by-zero; Start ignored while Busy.
// Optional divider datapath enabled by defining MDU_DIV_EN; otherwise divide ops complete in FIX without touching Hi/Lo.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   mult_div_unit_if.slave   bus
);

   localparam int CW = $clog2(WIDTH);

   state_e             r_state;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_b;
   logic               r_is_div;
   logic               r_neg_q;
   logic               r_busy;
   logic               r_done;
   logic               r_div_zero;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_sgn;
   logic               w_div;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_next;

   assign w_sgn = op_is_signed(bus.i_op);
   assign w_div = op_is_div(bus.i_op);

   mdu_cond_neg #(.W(WIDTH)) u_mag_a (
      .i_dat (bus.i_opa),
      .i_neg (w_sgn & bus.i_opa[WIDTH-1]),
      .o_dat (w_mag_a)
   );

   mdu_cond_neg #(.W(WIDTH)) u_mag_b (
      .i_dat (bus.i_opb),
      .i_neg (w_sgn & bus.i_opb[WIDTH-1]),
      .o_dat (w_mag_b)
   );

   mdu_cond_neg #(.W(2*WIDTH)) u_prod_fix (
      .i_dat (r_acc),
      .i_neg (r_neg_q),
      .o_dat (w_prod)
   );

   // Shift-add: multiplier sits in the low half and drains out of bit 0.
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef MDU_DIV_EN
   logic               r_neg_r;
   logic               r_dz_pend;
   logic [WIDTH:0]     w_div_shift;
   logic [WIDTH:0]     w_div_diff;
   logic [2*WIDTH-1:0] w_div_next;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   // Restoring divide: remainder in the high half, dividend shifts into it while quotient bits fill the low half.
   assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_div_diff  = w_div_shift - {1'b0, r_b};
   assign w_div_next  = w_div_diff[WIDTH] ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                          : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

   mdu_cond_neg #(.W(WIDTH)) u_quo_fix (
      .i_dat (r_acc[WIDTH-1:0]),
      .i_neg (r_neg_q),
      .o_dat (w_quo)
   );

   mdu_cond_neg #(.W(WIDTH)) u_rem_fix (
      .i_dat (r_acc[2*WIDTH-1:WIDTH]),
      .i_neg (r_neg_r),
      .o_dat (w_rem)
   );
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_b        <= '0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
`ifdef MDU_DIV_EN
         r_neg_r    <= 1'b0;
         r_dz_pend  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_busy     <= 1'b1;
                  r_div_zero <= 1'b0;
                  r_cnt      <= '0;
                  r_is_div   <= w_div;
                  r_b        <= w_mag_b;
                  r_neg_q    <= w_sgn & (bus.i_opa[WIDTH-1] ^ bus.i_opb[WIDTH-1]);
`ifdef MDU_DIV_EN
                  r_neg_r    <= w_sgn & bus.i_opa[WIDTH-1];
                  // Divide by zero keeps the raw dividend so it can be returned in Hi untouched.
                  if (w_div && (bus.i_opb == '0)) begin
                     r_dz_pend <= 1'b1;
                     r_acc     <= {{WIDTH{1'b0}}, bus.i_opa};
                     r_state   <= S_FIX;
                  end else begin
                     r_dz_pend <= 1'b0;
                     r_acc     <= {{WIDTH{1'b0}}, w_mag_a};
                     r_state   <= S_CALC;
                  end
`else
                  r_acc      <= {{WIDTH{1'b0}}, w_mag_a};
                  r_state    <= w_div ? S_FIX : S_CALC;
`endif
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + CW'(1);
`ifdef MDU_DIV_EN
               r_acc <= r_is_div ? w_div_next : w_mul_next;
`else
               r_acc <= w_mul_next;
`endif
               if (r_cnt == CW'(WIDTH-1))
                  r_state <= S_FIX;
            end
            S_FIX: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
               if (!r_is_div) begin
                  {r_hi, r_lo} <= w_prod;
               end
`ifdef MDU_DIV_EN
               else if (r_dz_pend) begin
                  r_hi       <= r_acc[WIDTH-1:0];
                  r_lo       <= {WIDTH{1'b1}};
                  r_div_zero <= 1'b1;
               end else begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_busy     = r_busy;
   assign bus.o_done     = r_done;
   assign bus.o_hi       = r_hi;
   assign bus.o_lo       = r_lo;
   assign bus.o_div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases then random ops against an arithmetic reference model.
// Expectations for divide ops follow MDU_DIV_EN the same way the design does.
module tb_mult_div_unit;
   import mdu_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n;

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0] exp_hi, exp_lo;
   logic         exp_dz;
   int           exp_cyc;

   always #5 clk = ~clk;

   mult_div_unit_if #(.WIDTH(W)) bus ();

   mult_div_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the architectural rules.
   task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint       sa, sb, q, r;
      logic [63:0]  p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      exp_cyc = W + 2;
      case (op)
         2'd0: begin
            p = {32'b0, a} * {32'b0, b};
            {exp_hi, exp_lo} = p;
            exp_dz = 1'b0;
         end
         2'd1: begin
            p = sa * sb;
            {exp_hi, exp_lo} = p;
            exp_dz = 1'b0;
         end
         default: begin
`ifdef MDU_DIV_EN
            if (b == 0) begin
               exp_cyc = 2;
               exp_lo  = '1;
               exp_hi  = a;
               exp_dz  = 1'b1;
            end else if (op == 2'd2) begin
               exp_lo = a / b;
               exp_hi = a % b;
               exp_dz = 1'b0;
            end else begin
               q = sa / sb;
               r = sa % sb;
               exp_lo = q[31:0];
               exp_hi = r[31:0];
               exp_dz = 1'b0;
            end
`else
            exp_cyc = 2;
            exp_dz  = 1'b0;
`endif
         end
      endcase
   endtask

   // Called at a negedge with the unit idle (or in its Done cycle).
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit repulse);
      logic [W-1:0] hold_hi, hold_lo;
      int  done_cyc, busy_cnt;
      bit  hold_ok, overlap;
      hold_hi  = exp_hi;
      hold_lo  = exp_lo;
      done_cyc = 0;
      busy_cnt = 0;
      hold_ok  = 1'b1;
      overlap  = 1'b0;
      model(op, a, b);
      bus.i_start = 1'b1;
      bus.i_op    = op_e'(op);
      bus.i_opa   = a;
      bus.i_opb   = b;
      @(posedge clk);
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 1) bus.i_start = 1'b0;
         if (repulse && c == 5) begin
            bus.i_start = 1'b1;
            bus.i_opa   = $urandom;
            bus.i_opb   = $urandom;
         end
         if (repulse && c == 6) bus.i_start = 1'b0;
         if (bus.o_busy && bus.o_done) overlap = 1'b1;
         if (bus.o_done) begin
            done_cyc = c;
            break;
         end
         if (bus.o_busy) busy_cnt++;
         if (bus.o_hi !== hold_hi || bus.o_lo !== hold_lo) hold_ok = 1'b0;
      end
      chk("done_cycle", done_cyc, exp_cyc);
      chk("busy_cycles", busy_cnt, exp_cyc - 1);
      chk("busy_done_overlap", overlap, 0);
      chk("hilo_hold_in_flight", hold_ok, 1);
      chk("hi", bus.o_hi, exp_hi);
      chk("lo", bus.o_lo, exp_lo);
      chk("div_zero", bus.o_div_zero, exp_dz);
   endtask

   initial begin
      int extra;
      logic [1:0]   op;
      logic [W-1:0] a, b;
      int           sel, gap;

      rst_n       = 1'b0;
      bus.i_start = 1'b0;
      bus.i_op    = OP_MULTU;
      bus.i_opa   = '0;
      bus.i_opb   = '0;
      exp_hi      = '0;
      exp_lo      = '0;
      exp_dz      = 1'b0;
      exp_cyc     = 0;

      repeat (3) @(negedge clk);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_done", bus.o_done, 0);
      chk("rst_hi", bus.o_hi, 0);
      chk("rst_lo", bus.o_lo, 0);
      chk("rst_div_zero", bus.o_div_zero, 0);
      rst_n = 1'b1;

      run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(2'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
      run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(2'd2, 32'h64, 32'd0, 1'b0);
      run_op(2'd0, 32'd7, 32'd9, 1'b1);

      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.o_done) extra++;
      end
      chk("single_done_after_repulse", extra, 0);

      // Reset in the middle of an operation discards it.
      bus.i_start = 1'b1;
      bus.i_op    = OP_MULT;
      bus.i_opa   = 32'h1234_5678;
      bus.i_opb   = 32'h9ABC_DEF0;
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) bus.i_start = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", bus.o_busy, 0);
      chk("midrst_done", bus.o_done, 0);
      chk("midrst_hi", bus.o_hi, 0);
      chk("midrst_lo", bus.o_lo, 0);
      chk("midrst_div_zero", bus.o_div_zero, 0);
      exp_hi = '0;
      exp_lo = '0;
      exp_dz = 1'b0;
      rst_n  = 1'b1;
      run_op(2'd0, 32'd2, 32'd3, 1'b0);

      for (int i = 0; i < 60; i++) begin
         op  = 2'($urandom_range(0, 3));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) b = '0;
         else if (sel == 1) b = 32'($urandom_range(1, 15));
         else if (sel == 2) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         gap = $urandom_range(0, 2);
         if (gap != 0) begin
            repeat (gap) @(negedge clk);
            chk("idle_hold", {bus.o_div_zero, bus.o_hi, bus.o_lo} == {exp_dz, exp_hi, exp_lo}, 1);
         end
         run_op(op, a, b, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit consuming ALU operand B from the ALUSrc operand mux (DataOut) and operand A from register port 1. It executes MULT/MULTU/DIV/DIVU over multiple cycles and holds the 64-bit result in architectural Hi/Lo registers. A Start/Busy/Done handshake lets the control unit stall the datapath while the unit runs.

## Interface
- WIDTH, 32, operand width; the iteration count equals WIDTH.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- Start  in  1  request; sampled only when Busy=0.
- Op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- OpA  in  WIDTH  operand A / dividend (ReadD1).
- OpB  in  WIDTH  operand B / divisor (operand mux DataOut).
- Busy  out  1  operation in flight.
- Done  out  1  one-cycle pulse; Hi/Lo valid from this cycle on.
- Hi  out  WIDTH  product high word / remainder.
- Lo  out  WIDTH  product low word / quotient.
- DivZero  out  1  last division had divisor 0; held until the next accepted Start.

## Operation
- States: IDLE, CALC, FIX.
  - IDLE with Start=1 goes to CALC. Operands are latched as magnitudes (signed ops take the absolute value), result signs are latched, the counter is cleared, and DivZero is cleared.
  - Exception: a division with OpB==0 goes from IDLE straight to FIX.
- CALC runs for exactly WIDTH cycles. Multiply is radix-2 shift-add on a 2·WIDTH accumulator. Divide is restoring: shift the remainder left, subtract the divisor, and keep the result if it is non-negative.
- FIX applies sign correction, writes Hi/Lo, pulses Done, and returns to IDLE.
- Signed rules:
  - Product is negated when sign(A)^sign(B).
  - Quotient is negated when sign(A)^sign(B).
  - Remainder takes sign(A).
- Divide by zero: Lo = all ones, Hi = OpA unmodified, DivZero = 1.
- DIV 0x80000000 / 0xFFFFFFFF: Lo = 0x80000000, Hi = 0. No trap.
- Start while Busy=1 is ignored. Operands are not re-sampled.
- Start in the Done cycle (state is IDLE) is accepted.
- Hi/Lo change only in FIX. They hold their value across IDLE and CALC.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, counter=0. This applies mid-operation as well; the in-flight result is discarded.
- Normal case, with Start accepted at edge 0:
  - Busy is high in cycles 1..WIDTH+1.
  - Done is high and Hi/Lo are valid in cycle WIDTH+2 (cycle 34 for WIDTH=32).
  - Busy is 0 in that cycle.
- Divide-by-zero: Busy is high in cycle 1 only; Done and DivZero are high in cycle 2.
- Busy and Done are registered outputs and are never high together.

## Configuration
- MDU_DIV_EN defined: full behaviour as above.
- MDU_DIV_EN undefined: the divider datapath is removed.
  - Op 10/11 is accepted and goes directly IDLE→FIX.
  - Done pulses in cycle 2.
  - Hi/Lo are unchanged and DivZero stays 0.
  - Multiply behaviour and latency are unchanged.

## Structure
- Package mdu_pkg holds:
  - Op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV.
  - State enum: S_IDLE, S_CALC, S_FIX.
  - Default width constant MDU_WIDTH=32.
- One sub-module: mdu_cond_neg, a parameterized conditional two's-complement negate. It is used for operand magnitude on input and for product/quotient/remainder sign fix in FIX.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001; Done in cycle 34, Busy cycles 1..33.
- MULT 0xFFFFFFFD (−3) × 5 → Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (−7) / 2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0, DivZero=0.
- DIVU 0x64 / 0 → Done in cycle 2, DivZero=1, Lo=0xFFFFFFFF, Hi=0x64. With MDU_DIV_EN undefined: Done in cycle 2, Hi/Lo unchanged, DivZero=0.
- Reset and Start interaction:
  - MULTU 7 × 9 with Start re-pulsed at cycle 5 using different operands → Hi=0, Lo=63, a single Done.
  - rst_n low at cycle 10 of a second op → all outputs 0. A following MULTU 2 × 3 → Lo=6.
